// File: rtl/emmc_pkg.sv
// Shared eMMC CMD-line definitions: frame geometry, CRC7 polynomial,
// transmitter state encoding, command payload layout and the CRC7 step.
package emmc_pkg;

  localparam int unsigned CMD_FRAME_BITS   = 48;
  localparam int unsigned CMD_PAYLOAD_BITS = 40;
  localparam int unsigned CRC7_BITS        = 7;
  localparam int unsigned CMD_INDEX_BITS   = 6;
  localparam int unsigned CMD_ARG_BITS     = 32;

  // x^7 + x^3 + 1 with the x^7 term implied
  localparam logic [CRC7_BITS-1:0] CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_CRC,
    ST_END,
    ST_RELEASE,
    ST_GAP
  } cmd_tx_state_t;

  // First 40 bits on the wire: start 0, transmission 1, index, argument
  typedef struct packed {
    logic [1:0]                hdr;
    logic [CMD_INDEX_BITS-1:0] index;
    logic [CMD_ARG_BITS-1:0]   arg;
  } cmd_payload_t;

  // One serial CRC7 step for a single message bit
  function automatic logic [CRC7_BITS-1:0] crc7_next(
    input logic [CRC7_BITS-1:0] crc,
    input logic                 bit_in
  );
    logic fb;
    fb = bit_in ^ crc[CRC7_BITS-1];
    return {crc[CRC7_BITS-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
  endfunction

endpackage

// File: rtl/crc7_serial_gen.sv
// Serial CRC7 register, one message bit per enabled clock.
// Ports: clk, rstn (sync, active low), clr (zero the register, wins over en),
//        en (absorb bit_in), bit_in, crc (current register value).
// Feeding bit_in = crc[6] shifts the register left with zero fill, which is
// how the transmitter clocks the finished CRC out MSB first.
module crc7_serial_gen
  import emmc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 bit_in,
  output logic [CRC7_BITS-1:0] crc
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc7_next(crc, bit_in);
    end
  end

endmodule

// File: rtl/emmc_cmd_tx.sv
// Host-side eMMC CMD-line frame serializer.
// Accepts {index, argument} on a valid/ready handshake and sends the 48-bit
// frame MSB first (start, transmission, index, arg, CRC7, end), one bit per
// bit_en strobe, followed by GAP_BITS strobes of released line.
// Ports: clk, rstn (sync, active low), bit_en (bit strobe),
//        cmd_valid/cmd_ready/cmd_index/cmd_arg (command request),
//        cmd_out/cmd_oe (CMD pad), busy (accept..idle), done (end bit released).
module emmc_cmd_tx
  import emmc_pkg::*;
#(
  parameter int unsigned GAP_BITS = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      bit_en,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [CMD_INDEX_BITS-1:0] cmd_index,
  input  logic [CMD_ARG_BITS-1:0]   cmd_arg,
  output logic                      cmd_out,
  output logic                      cmd_oe,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned CNT_MAX  = (GAP_BITS > CMD_PAYLOAD_BITS) ? GAP_BITS : CMD_PAYLOAD_BITS;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned GAP_LAST = (GAP_BITS == 0) ? 0 : GAP_BITS - 1;

  cmd_tx_state_t                 state;
  logic [CMD_PAYLOAD_BITS-1:0]   shift_q;
  logic [CNT_W-1:0]              bit_cnt;
  logic [CRC7_BITS-1:0]          crc;
  cmd_payload_t                  payload;
  logic                          accept;
  logic                          crc_en;
  logic                          crc_bit;
  logic                          unused_crc_low;

  // Handshake and CRC feed: message bits in DATA, self-shift in CRC
  always_comb begin
    payload = '{hdr: 2'b01, index: cmd_index, arg: cmd_arg};
    accept  = cmd_valid & cmd_ready & (state == ST_IDLE);
    crc_en  = bit_en & ((state == ST_DATA) | (state == ST_CRC));
    crc_bit = (state == ST_DATA) ? shift_q[CMD_PAYLOAD_BITS-1] : crc[CRC7_BITS-1];
  end

  // Lower CRC bits reach the line only through the register's own shift
  assign unused_crc_low = ^crc[CRC7_BITS-2:0];

  crc7_serial_gen u_crc (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (accept),
    .en     (crc_en),
    .bit_in (crc_bit),
    .crc    (crc)
  );

  // Frame sequencer with registered line, handshake and status outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt   <= '0;
      cmd_out   <= 1'b1;
      cmd_oe    <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A strobe on the accept edge is deliberately not used
          if (accept) begin
            shift_q   <= payload;
            bit_cnt   <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_en) begin
            cmd_out <= shift_q[CMD_PAYLOAD_BITS-1];
            cmd_oe  <= 1'b1;
            shift_q <= {shift_q[CMD_PAYLOAD_BITS-2:0], 1'b0};
            if (bit_cnt == CNT_W'(CMD_PAYLOAD_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= ST_CRC;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        ST_CRC: begin
          if (bit_en) begin
            cmd_out <= crc[CRC7_BITS-1];
            cmd_oe  <= 1'b1;
            if (bit_cnt == CNT_W'(CRC7_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= ST_END;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        ST_END: begin
          if (bit_en) begin
            cmd_out <= 1'b1;
            cmd_oe  <= 1'b1;
            state   <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (bit_en) begin
            cmd_oe  <= 1'b0;
            cmd_out <= 1'b1;
            done    <= 1'b1;
            bit_cnt <= '0;
            if (GAP_BITS == 0) begin
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (bit_en) begin
            if (bit_cnt == CNT_W'(GAP_LAST)) begin
              bit_cnt   <= '0;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
